// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg
// Shared constants for the memory responder: FSM state encodings, the data
// returned for out-of-range reads, and the legal wait-state range together
// with a helper that turns a latency into the WAIT counter preload value.
package mem_responder_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_TURN = 2'd3;

  localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 255;

  // Counter preload is latency-1 because the acceptance edge is the first
  // cycle of the latency; out-of-range settings are clamped to the legal range.
  function automatic logic [7:0] lat_load(input int lat);
    int l;
    l = lat;
    if (l < LAT_MIN) l = LAT_MIN;
    if (l > LAT_MAX) l = LAT_MAX;
    return 8'(l - 1);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if
// Native 32-bit memory bus between an initiator (cache mem_*_m port) and the
// memory responder.
//   mem_valid  request present          mem_instr  instruction fetch flag
//   mem_addr   byte address             mem_wdata  write data
//   mem_wstrb  byte enables, 0 = read   mem_ready  one-cycle completion pulse
//   mem_rdata  read data, valid with mem_ready
interface mem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_responder_sram.sv
// mem_responder_sram
// Single-port MEM_WORDS x 32 array with per-byte write enables and a
// registered read port. A cycle with i_en and any i_we bit writes; a cycle
// with i_en and i_we == 0 reads. o_rdata holds its value between reads.
//   clk      clock            i_en     access enable
//   i_we     byte write mask  i_addr   word index
//   i_wdata  write data       o_rdata  registered read data
module mem_responder_sram #(
  parameter int MEM_WORDS = 16384,
  parameter int ADDR_W    = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (|i_we) begin
        for (int i = 0; i < 4; i++) begin
          if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// mem_responder
// Latency-configurable main-memory responder. Accepts one request at a time,
// waits READ_LATENCY / WRITE_LATENCY cycles, completes the access with a
// one-cycle mem_ready pulse, then spends one turnaround cycle before it can
// accept again. Keeps completion statistics.
//   clk, reset    clock, synchronous active-high reset
//   bus           memory bus, slave side
//   busy          high from the cycle after acceptance through turnaround
//   rd_count      completed in-range reads
//   wr_count      completed in-range writes
//   ifetch_count  completed reads flagged as instruction fetches
//   oor_count     completed out-of-range requests
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int MEM_WORDS     = 16384,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_responder_if.slave       bus,
  output logic                 busy,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [31:0]          ifetch_count,
  output logic [31:0]          oor_count
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam logic [7:0] RD_LOAD = lat_load(READ_LATENCY);
  localparam logic [7:0] WR_LOAD = lat_load(WRITE_LATENCY);

  logic [1:0]  r_state;
  logic [7:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_instr;
  logic        r_ready;
  logic        r_busy;
  logic        r_rd_zero;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;
  logic [31:0] r_if_count;
  logic [31:0] r_oor_count;

  logic        w_fire;
  logic        w_in_range;
  logic        w_is_wr;
  logic        w_sram_en;
  logic [31:0] w_sram_rdata;
  logic        w_unused;

  assign w_fire     = (r_state == S_WAIT) && (r_cnt == 8'd0);
  assign w_in_range = (r_addr[31:ADDR_W+2] == '0);
  assign w_is_wr    = |r_wstrb;
  // Gated by reset so an aborted request never touches the array.
  assign w_sram_en  = w_fire && w_in_range && !reset;
  assign w_unused   = &{1'b0, r_addr[1:0]};

  mem_responder_sram #(
    .MEM_WORDS (MEM_WORDS),
    .ADDR_W    (ADDR_W)
  ) u_sram (
    .clk     (clk),
    .i_en    (w_sram_en),
    .i_we    (r_wstrb),
    .i_addr  (r_addr[ADDR_W+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

  // The array read register only updates on in-range reads, so it already
  // holds the last read word; r_rd_zero overrides it after reset and after an
  // out-of-range read.
  assign bus.mem_rdata = r_rd_zero ? OOR_RDATA : w_sram_rdata;
  assign bus.mem_ready = r_ready;
  assign busy          = r_busy;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;
  assign ifetch_count  = r_if_count;
  assign oor_count     = r_oor_count;

  // Request capture: bus inputs are only looked at in IDLE.
  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && bus.mem_valid) begin
      r_addr  <= bus.mem_addr;
      r_wdata <= bus.mem_wdata;
      r_wstrb <= bus.mem_wstrb;
      r_instr <= bus.mem_instr;
    end
  end

  // Control FSM and statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 8'd0;
      r_ready     <= 1'b0;
      r_busy      <= 1'b0;
      r_rd_zero   <= 1'b1;
      r_rd_count  <= 32'd0;
      r_wr_count  <= 32'd0;
      r_if_count  <= 32'd0;
      r_oor_count <= 32'd0;
    end else begin
      // Registered from the state, so busy trails the FSM by one cycle.
      r_busy <= (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (bus.mem_valid) begin
            r_state <= S_WAIT;
            r_cnt   <= (|bus.mem_wstrb) ? WR_LOAD : RD_LOAD;
          end
        end
        S_WAIT: begin
          if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
          end else begin
            r_ready <= 1'b1;
            r_state <= S_RESP;
            if (!w_in_range) begin
              r_oor_count <= r_oor_count + 32'd1;
              if (!w_is_wr) r_rd_zero <= 1'b1;
            end else if (w_is_wr) begin
              r_wr_count <= r_wr_count + 32'd1;
            end else begin
              r_rd_count <= r_rd_count + 32'd1;
              r_rd_zero  <= 1'b0;
              if (r_instr) r_if_count <= r_if_count + 32'd1;
            end
          end
        end
        S_RESP: begin
          r_ready <= 1'b0;
          r_state <= S_TURN;
        end
        S_TURN: begin
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder
// Directed bench for mem_responder with default latencies (4/4).
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        busy;
  logic [31:0] rd_count, wr_count, ifetch_count, oor_count;
  int          n_tests;
  int          n_fail;

  mem_responder_if bus();

  mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .busy         (busy),
    .rd_count     (rd_count),
    .wr_count     (wr_count),
    .ifetch_count (ifetch_count),
    .oor_count    (oor_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One isolated request. lat = edges from acceptance to the ready sample
  // (-1 if ready never came). Also samples busy/ready around the transaction.
  task automatic do_req(input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic ins,
                        output int lat, output logic [31:0] rd,
                        output logic b0, output logic b1,
                        output logic rdy_after, output logic b_turn,
                        output logic b_end);
    lat = -1; rd = 32'hDEAD_BEEF; b1 = 1'b0;
    rdy_after = 1'b1; b_turn = 1'b0; b_end = 1'b1;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
    bus.mem_wstrb = s; bus.mem_instr = ins;
    @(posedge clk); #1;
    b0 = busy;
    @(negedge clk);
    bus.mem_valid = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) b1 = busy;
      if (bus.mem_ready) begin
        lat = n;
        rd  = bus.mem_rdata;
        break;
      end
    end
    @(posedge clk); #1; rdy_after = bus.mem_ready;
    @(posedge clk); #1; b_turn = busy;
    @(posedge clk); #1; b_end = busy;
  endtask

  task automatic test_reset();
    pulse_reset();
    #1;
    n_tests++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.mem_ready); end
    n_tests++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 00000000", bus.mem_rdata); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_tests++; if (rd_count !== 32'd0) begin n_fail++; $display("FAIL reset_rd_count: got %0d want 0", rd_count); end
    n_tests++; if (wr_count !== 32'd0) begin n_fail++; $display("FAIL reset_wr_count: got %0d want 0", wr_count); end
    n_tests++; if (ifetch_count !== 32'd0) begin n_fail++; $display("FAIL reset_ifetch_count: got %0d want 0", ifetch_count); end
    n_tests++; if (oor_count !== 32'd0) begin n_fail++; $display("FAIL reset_oor_count: got %0d want 0", oor_count); end
  endtask

  task automatic test_read_latency();
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    do_req(32'h40, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL rd_latency: got %0d want 4", lat); end
    n_tests++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL rd_data: got %h want cafef00d", rd); end
    n_tests++; if (rd_count !== 32'd1) begin n_fail++; $display("FAIL rd_count: got %0d want 1", rd_count); end
    n_tests++; if (ra !== 1'b0) begin n_fail++; $display("FAIL rd_ready_pulse_width: got %b want 0", ra); end
    n_tests++; if (b0 !== 1'b0) begin n_fail++; $display("FAIL busy_at_accept: got %b want 0", b0); end
    n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL busy_rise: got %b want 1", b1); end
    n_tests++; if (bt !== 1'b1) begin n_fail++; $display("FAIL busy_turn: got %b want 1", bt); end
    n_tests++; if (be !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", be); end
  endtask

  task automatic test_byte_strobe();
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    do_req(32'h0, 32'hAABB_CCDD, 4'b0101, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL wr_latency: got %0d want 4", lat); end
    n_tests++; if (wr_count !== 32'd1) begin n_fail++; $display("FAIL wr_count: got %0d want 1", wr_count); end
    do_req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL strobe_merge: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    logic [31:0] wr0;
    wr0 = wr_count;
    t1 = -1; t2 = -1;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'hA0A0_A0A0;
    bus.mem_wstrb = 4'hF; bus.mem_instr = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (bus.mem_ready) begin
        if (t1 < 0) begin
          t1 = c;
          @(negedge clk);
          bus.mem_addr = 32'h104; bus.mem_wdata = 32'hB1B1_B1B1;
        end else begin
          t2 = c;
          break;
        end
      end
    end
    @(negedge clk);
    bus.mem_valid = 1'b0;
    repeat (4) @(posedge clk);
    n_tests++; if (t1 !== 5) begin n_fail++; $display("FAIL b2b_first_ready: got %0d want 5", t1); end
    n_tests++; if (t2 - t1 !== 7) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 7", t2 - t1); end
    n_tests++; if (wr_count - wr0 !== 32'd2) begin n_fail++; $display("FAIL b2b_wr_count: got %0d want 2", wr_count - wr0); end
    do_req(32'h100, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (rd !== 32'hA0A0_A0A0) begin n_fail++; $display("FAIL b2b_word40: got %h want a0a0a0a0", rd); end
    do_req(32'h104, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (rd !== 32'hB1B1_B1B1) begin n_fail++; $display("FAIL b2b_word41: got %h want b1b1b1b1", rd); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    logic [31:0] wr0, rd0, oor0;
    wr0 = wr_count; rd0 = rd_count; oor0 = oor_count;
    do_req(32'h0001_0000, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL oor_rd_latency: got %0d want 4", lat); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oor_rd_data: got %h want 00000000", rd); end
    n_tests++; if (oor_count - oor0 !== 32'd1) begin n_fail++; $display("FAIL oor_count_rd: got %0d want 1", oor_count - oor0); end
    n_tests++; if (rd_count !== rd0) begin n_fail++; $display("FAIL oor_rd_count: got %0d want %0d", rd_count, rd0); end
    do_req(32'h0002_0000, 32'h9999_9999, 4'hF, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (lat !== 4) begin n_fail++; $display("FAIL oor_wr_latency: got %0d want 4", lat); end
    n_tests++; if (wr_count !== wr0) begin n_fail++; $display("FAIL oor_wr_count: got %0d want %0d", wr_count, wr0); end
    n_tests++; if (oor_count - oor0 !== 32'd2) begin n_fail++; $display("FAIL oor_count_wr: got %0d want 2", oor_count - oor0); end
    do_req(32'h0, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (rd !== 32'h11BB_33DD) begin n_fail++; $display("FAIL oor_wr_dropped: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    logic saw_ready;
    do_req(32'h20, 32'h1234_5678, 4'hF, 1'b0, lat, rd, b0, b1, ra, bt, be);
    pulse_reset();
    saw_ready = 1'b0;
    @(negedge clk);
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h20; bus.mem_wdata = 32'h5555_5555;
    bus.mem_wstrb = 4'hF; bus.mem_instr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.mem_valid = 1'b0;
    @(posedge clk); #1; saw_ready |= bus.mem_ready;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin @(posedge clk); #1; saw_ready |= bus.mem_ready; end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) begin @(posedge clk); #1; saw_ready |= bus.mem_ready; end
    n_tests++; if (saw_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_ready: got %b want 0", saw_ready); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy); end
    n_tests++; if (wr_count !== 32'd0) begin n_fail++; $display("FAIL abort_wr_count: got %0d want 0", wr_count); end
    n_tests++; if (oor_count !== 32'd0) begin n_fail++; $display("FAIL abort_oor_count: got %0d want 0", oor_count); end
    do_req(32'h20, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (rd !== 32'h1234_5678) begin n_fail++; $display("FAIL abort_array_unchanged: got %h want 12345678", rd); end
  endtask

  task automatic test_ifetch();
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    pulse_reset();
    do_req(32'h40, 32'h0, 4'h0, 1'b1, lat, rd, b0, b1, ra, bt, be);
    do_req(32'h44, 32'h0, 4'h0, 1'b1, lat, rd, b0, b1, ra, bt, be);
    do_req(32'h48, 32'h0, 4'h0, 1'b0, lat, rd, b0, b1, ra, bt, be);
    do_req(32'h4C, 32'h0, 4'h0, 1'b1, lat, rd, b0, b1, ra, bt, be);
    n_tests++; if (ifetch_count !== 32'd3) begin n_fail++; $display("FAIL ifetch_count: got %0d want 3", ifetch_count); end
    n_tests++; if (rd_count !== 32'd4) begin n_fail++; $display("FAIL ifetch_rd_count: got %0d want 4", rd_count); end
  endtask

  initial begin
    int lat; logic [31:0] rd; logic b0, b1, ra, bt, be;
    n_tests = 0; n_fail = 0;
    reset = 1'b1;
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = 32'h0;
    bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    test_reset();
    // Preload through the bus, then clear the statistics.
    do_req(32'h40, 32'hCAFE_F00D, 4'hF, 1'b0, lat, rd, b0, b1, ra, bt, be);
    do_req(32'h0, 32'h1122_3344, 4'hF, 1'b0, lat, rd, b0, b1, ra, bt, be);
    pulse_reset();
    test_read_latency();
    test_byte_strobe();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_wait();
    test_ifetch();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Latency-configurable main-memory responder for the native 32-bit memory bus, the memory-side end of the cache's `mem_*_m` port. It accepts one request at a time, inserts a programmable number of wait states, then completes a byte-strobed write or a word read with a one-cycle `mem_ready` pulse. It holds the backing SRAM array, reports out-of-range accesses, and keeps access statistics for hit/miss studies.

## Interface
- `MEM_WORDS`, 16384, array depth in 32-bit words (64 kB); `ADDR_W = $clog2(MEM_WORDS)`.
- `READ_LATENCY`, 4, cycles from request acceptance to read `mem_ready`; legal range 1..255.
- `WRITE_LATENCY`, 4, cycles from request acceptance to write `mem_ready`; legal range 1..255.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_valid`  in  1  request present.
- `mem_instr`  in  1  request is an instruction fetch; statistics only.
- `mem_addr`  in  32  byte address; `[1:0]` ignored.
- `mem_wdata`  in  32  write data.
- `mem_wstrb`  in  4  byte enables; 0 means read.
- `mem_ready`  out  1  one-cycle completion pulse.
- `mem_rdata`  out  32  read data, valid while `mem_ready` is high; held until the next read completes.
- `busy`  out  1  high from acceptance through the turnaround cycle.
- `rd_count`  out  32  completed in-range reads.
- `wr_count`  out  32  completed in-range writes.
- `ifetch_count`  out  32  completed reads with `mem_instr`=1.
- `oor_count`  out  32  completed out-of-range requests.

## Operation
- States: IDLE, WAIT, RESP, TURN.
- IDLE:
  - `mem_valid`=1 at an edge accepts the request.
  - Latches addr, wdata, wstrb and instr.
  - Loads `cnt` = LATENCY-1, using `WRITE_LATENCY` when `|wstrb`, else `READ_LATENCY`.
  - Next state is WAIT.
- WAIT:
  - `cnt`≠0: decrement.
  - `cnt`=0: perform the access, set `mem_ready`<=1, go to RESP.
  - Bus inputs are ignored; only the latched values are used.
- RESP:
  - `mem_ready`<=0, go to TURN.
- TURN:
  - One mandatory turnaround cycle; `mem_valid` is ignored.
  - Go to IDLE.
  - Rationale: initiators may keep `mem_valid` high and update `mem_addr` one cycle after they see `mem_ready`.
- Range check: in range iff `addr[31:ADDR_W+2]`=0. Word index = `addr[ADDR_W+1:2]`.
- Write, in range: byte `i` of the word is written from `wdata[8i+:8]` only when `wstrb[i]`; `wr_count`+1.
- Read, in range: `mem_rdata` <= word; `rd_count`+1; `ifetch_count`+1 if instr.
- Out of range:
  - The request still completes after its latency, so the bus never hangs.
  - Read returns 32'h0000_0000.
  - Write is dropped.
  - `oor_count`+1; `rd_count` and `wr_count` are unchanged.
- Counters wrap modulo 2^32.
- Reset:
  - IDLE, `mem_ready`=0, `mem_rdata`=0, `busy`=0, all counters=0.
  - An in-flight request is aborted with no array write and no counter update.
  - Array contents are not cleared.

## Timing
- Request sampled at edge E0.
- `mem_ready` is high for exactly the cycle following edge E0+L.
- The array write and the `mem_rdata` update both occur at edge E0+L.
- Earliest next acceptance is edge E0+L+3, so back-to-back responses are spaced L+3 cycles apart.
- With L=1: accept E0, ready during E1–E2, TURN E2–E3, IDLE from E3, next accept E4.
- Counters update at the same edge as the `mem_ready` rise.
- `busy` rises at E0+1 and falls at E0+L+3.
- `mem_valid` dropping during WAIT does not cancel the request.

## Structure
- Package/header `mem_responder_pkg`:
  - State encodings: IDLE=0, WAIT=1, RESP=2, TURN=3.
  - `OOR_RDATA`=32'h0.
  - Latency bounds.
- Sub-module `mem_responder_sram`:
  - Single-port array of `MEM_WORDS`×32 with 4-bit byte-write enable and registered read.
  - The FSM drives it in the WAIT→RESP transition cycle.
  - `$readmemh` preload is a bench hook only.

## Test plan
- Read latency: preload word 0x10 = 32'hCAFE_F00D, READ_LATENCY=4; read addr 0x40 → `mem_ready` one cycle, 4 cycles after acceptance, `mem_rdata`=32'hCAFE_F00D, `rd_count`=1.
- Byte-strobe write: word 0x0 = 32'h1122_3344; write wdata 32'hAABB_CCDD with wstrb 4'b0101, then read addr 0x0 → 32'h11BB_33DD, `wr_count`=1.
- Held valid and turnaround: hold `mem_valid` high; issue write 0x100 followed by write 0x104 changing addr the cycle after ready → two writes land at words 0x40 and 0x41; ready pulses L+3 cycles apart.
- Out of range: read 0x0001_0000 → `mem_rdata`=0 after READ_LATENCY and `oor_count`=1; write 0x0002_0000 → ready pulses, array unchanged, `wr_count` unchanged.
- Reset mid-WAIT: accept write of 32'h5555_5555 to 0x20, assert `reset` at cycle 2 of 4 → no ready pulse, word 0x8 unchanged, counters 0, `busy`=0.
- Instruction-fetch statistics: three reads with `mem_instr`=1 and one with `mem_instr`=0 → `ifetch_count`=3, `rd_count`=4.
